// File: rtl/bw_ctu_jbus_clsp_seq.sv
// J-Bus cluster header sequencer: orders clock enable, global reset release and
// debug-init pulses for one clock cluster, and reverses the order on stop.
module bw_ctu_jbus_clsp_seq #(
   parameter int CNT_W    = 4,
   parameter int CKEN_DLY = 4,
   parameter int DBG_LEN  = 3,
   parameter int STOP_DLY = 2
) (
   input  logic rclk,
   input  logic arst_l,
   input  logic start_req,
   input  logic stop_req,
   input  logic dbg_req,
   output logic cluster_cken,
   output logic grst_l,
   output logic gdbginit_l,
   output logic dbg_ack,
   output logic stopped
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CKEN = 3'd1,
      RUN  = 3'd2,
      DBG  = 3'd3,
      STOP = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CKEN_LD = CNT_W'(CKEN_DLY - 1);
   localparam logic [CNT_W-1:0] DBG_LD  = CNT_W'(DBG_LEN - 1);
   localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_DLY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_zero;
   logic             dbg_done;

   logic cken_d, grst_d, gdbg_d, ack_d, stopped_d;

   assign cnt_zero = (cnt_q == '0);

   // State and shared delay counter
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; stop always wins over debug and over the bring-up delay
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_zero ? '0 : cnt_q - CNT_W'(1);
      dbg_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_req && !stop_req) begin
               state_d = CKEN;
               cnt_d   = CKEN_LD;
            end
         end
         CKEN: begin
            if (stop_req) begin
               state_d = STOP;
               cnt_d   = STOP_LD;
            end else if (cnt_zero) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop_req) begin
               state_d = STOP;
               cnt_d   = STOP_LD;
            end else if (dbg_req) begin
               state_d = DBG;
               cnt_d   = DBG_LD;
            end
         end
         DBG: begin
            if (stop_req) begin
               state_d = STOP;
               cnt_d   = STOP_LD;
            end else if (cnt_zero) begin
               state_d  = RUN;
               dbg_done = 1'b1;
            end
         end
         STOP: begin
            if (cnt_zero) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values are decoded from the next state so the flops below
   // change on the same edge as the state transition.
   always_comb begin
      cken_d    = (state_d != IDLE);
      grst_d    = (state_d == RUN) || (state_d == DBG);
      gdbg_d    = (state_d == RUN);
      stopped_d = (state_d == IDLE);
      ack_d     = dbg_done;
   end

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         cluster_cken <= 1'b0;
         grst_l       <= 1'b0;
         gdbginit_l   <= 1'b0;
         dbg_ack      <= 1'b0;
         stopped      <= 1'b1;
      end else begin
         cluster_cken <= cken_d;
         grst_l       <= grst_d;
         gdbginit_l   <= gdbg_d;
         dbg_ack      <= ack_d;
         stopped      <= stopped_d;
      end
   end

endmodule

// File: tb/tb_bw_ctu_jbus_clsp_seq.sv
// Directed plus random bench for bw_ctu_jbus_clsp_seq against an
// elapsed-cycle model of the cluster bring-up/debug/stop rules.
module tb_bw_ctu_jbus_clsp_seq;

   localparam int CNT_W    = 4;
   localparam int CKEN_DLY = 4;
   localparam int DBG_LEN  = 3;
   localparam int STOP_DLY = 2;

   logic rclk = 1'b0;
   logic arst_l = 1'b0;
   logic start_req = 1'b0, stop_req = 1'b0, dbg_req = 1'b0;
   logic cluster_cken, grst_l, gdbginit_l, dbg_ack, stopped;

   int n_cmp = 0;
   int n_err = 0;

   // model: clock on, reset released, cycles since clock on, debug cycles left,
   // stop cycles left, ack this cycle
   bit m_on, m_rel, m_ack;
   int m_age, m_dbg_left, m_stop_left;

   bw_ctu_jbus_clsp_seq #(
      .CNT_W(CNT_W), .CKEN_DLY(CKEN_DLY), .DBG_LEN(DBG_LEN), .STOP_DLY(STOP_DLY)
   ) dut (
      .rclk(rclk), .arst_l(arst_l),
      .start_req(start_req), .stop_req(stop_req), .dbg_req(dbg_req),
      .cluster_cken(cluster_cken), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
      .dbg_ack(dbg_ack), .stopped(stopped)
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_on = 0; m_rel = 0; m_ack = 0;
      m_age = 0; m_dbg_left = 0; m_stop_left = 0;
   endtask

   task automatic m_edge(input bit s, input bit p, input bit d);
      m_ack = 0;
      if (!m_on) begin
         if (s && !p) begin
            m_on = 1; m_age = 0;
         end
      end else if (m_stop_left > 0) begin
         m_stop_left--;
         if (m_stop_left == 0) m_on = 0;
      end else if (p) begin
         m_stop_left = STOP_DLY;
         m_rel = 0; m_dbg_left = 0;
      end else if (!m_rel) begin
         m_age++;
         if (m_age == CKEN_DLY) m_rel = 1;
      end else if (m_dbg_left > 0) begin
         m_dbg_left--;
         if (m_dbg_left == 0) m_ack = 1;
      end else if (d) begin
         m_dbg_left = DBG_LEN;
      end
   endtask

   task automatic chk_all(input string where);
      chk({where, ".cluster_cken"}, cluster_cken, m_on);
      chk({where, ".grst_l"}, grst_l, m_rel);
      chk({where, ".gdbginit_l"}, gdbginit_l, m_rel && (m_dbg_left == 0));
      chk({where, ".dbg_ack"}, dbg_ack, m_ack);
      chk({where, ".stopped"}, stopped, !m_on);
   endtask

   // one clock cycle: drive, edge, advance model, sample 1 time unit later
   task automatic step(input string where, input bit s, input bit p, input bit d);
      start_req = s; stop_req = p; dbg_req = d;
      @(posedge rclk);
      if (arst_l) m_edge(s, p, d);
      #1;
      chk_all(where);
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge rclk);
      #1;
      chk_all("reset");
      @(negedge rclk) arst_l = 1'b1;

      // bring-up, debug pulse at cycle 10, stop/dbg collision at cycle 20
      for (int c = 0; c < 10; c++) step("bringup", 1, 0, 0);
      chk("bringup.grst_released", grst_l, 1'b1);
      step("dbg", 1, 0, 1);
      for (int c = 11; c < 20; c++) step("dbg", 1, 0, 0);
      step("collide", 1, 1, 1);
      for (int c = 21; c < 30; c++) step("start_blocked", 1, 1, 0);
      chk("blocked.stopped", stopped, 1'b1);
      step("unblock", 1, 0, 0);
      chk("unblock.cken", cluster_cken, 1'b1);

      // stop mid-debug: no ack
      for (int c = 0; c < 6; c++) step("run2", 0, 0, 0);
      step("dbg2", 0, 0, 1);
      step("dbg2", 0, 0, 1);
      step("dbg_abort", 0, 1, 0);
      for (int c = 0; c < 4; c++) step("dbg_abort", 0, 0, 0);

      // stop during bring-up
      step("cken_abort", 1, 0, 0);
      step("cken_abort", 1, 0, 0);
      step("cken_abort", 0, 1, 0);
      for (int c = 0; c < 6; c++) step("cken_abort", 0, 0, 0);

      // async reset mid-debug
      for (int c = 0; c < 6; c++) step("run3", 1, 0, 0);
      step("dbg3", 0, 0, 1);
      step("dbg3", 0, 0, 0);
      #2 arst_l = 1'b0;
      #1;
      m_reset();
      chk_all("async_rst");
      step("in_rst", 1, 0, 0);
      @(negedge rclk) arst_l = 1'b1;
      for (int c = 0; c < 5; c++) step("post_rst_idle", 0, 0, 0);
      step("post_rst_start", 1, 0, 0);

      // random traffic
      for (int c = 0; c < 600; c++)
         step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 3) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
